// File: rtl/u_pkg.sv
// ---------------------------------------------------------------------------
// u_pkg -- shared types and helpers for the u_stream unary-code pipeline.
//
// Contents:
//   U_W        build-wide input word width (default for u_stream / u_classify)
//   K_W        width of the decoded run length, $clog2(U_W)
//   STAT_MAX_W widest statistics counter the saturating helper supports
//   u_res_t    classification result {is_unary, is_cpl, k}
//   sat_inc    saturating increment used by the optional statistics counters
// ---------------------------------------------------------------------------
package u_pkg;

  localparam int unsigned U_W        = 16;
  localparam int unsigned K_W        = $clog2(U_W);
  localparam int unsigned STAT_MAX_W = 32;

  typedef struct packed {
    logic           is_unary;  // word is an admitted code (either form)
    logic           is_cpl;    // admitted word was the complimented form
    logic [K_W-1:0] k;         // decoded run length
  } u_res_t;

  // Increment v unless it has already reached lim. Narrower counters are
  // zero-extended into this width by the caller.
  function automatic logic [STAT_MAX_W-1:0] sat_inc(
    input logic [STAT_MAX_W-1:0] v,
    input logic [STAT_MAX_W-1:0] lim
  );
    return (v >= lim) ? v : v + STAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/u_classify.sv
// ---------------------------------------------------------------------------
// u_classify -- combinational pivot-match classifier for unary codes.
//
// For every pivot k the word is split into a low side x[k-1:0] and a high
// side x[W-1:k]. The true form matches when the low side is all ones and the
// high side all zeros; the complimented form is the mirror image. At most one
// pivot can match (the forms are disjoint for W >= 3), so k is the plain
// binary encoding of the matching pivot index.
//
// Ports:
//   x    in   W        word to classify
//   res  out  u_res_t  {is_unary, is_cpl, k}; all zero for a rejected word
// ---------------------------------------------------------------------------
module u_classify
  import u_pkg::*;
#(
  parameter int unsigned W                     = U_W,
  parameter int unsigned P_ADMIT_COMPLIMENT_EN = 1
) (
  input  logic [W-1:0] x,
  output u_res_t       res
);

  logic [W-1:0] m_true;
  logic [W-1:0] m_cpl;

  // NOTE: every variable written in always_comb gets a default before any
  // conditional logic, so no path can leave it holding state (a latch).
  always_comb begin
    logic lo_one, lo_zero, hi_one, hi_zero;
    m_true  = '0;
    m_cpl   = '0;
    lo_one  = 1'b1;
    lo_zero = 1'b1;
    hi_one  = 1'b1;
    hi_zero = 1'b1;
    for (int k = 0; k < W; k++) begin
      lo_one  = 1'b1;
      lo_zero = 1'b1;
      hi_one  = 1'b1;
      hi_zero = 1'b1;
      for (int b = 0; b < W; b++) begin
        if (b < k) begin
          lo_one  = lo_one  &  x[b];
          lo_zero = lo_zero & ~x[b];
        end else begin
          hi_one  = hi_one  &  x[b];
          hi_zero = hi_zero & ~x[b];
        end
      end
      m_true[k] = lo_one & hi_zero;
      m_cpl[k]  = (P_ADMIT_COMPLIMENT_EN != 0) & lo_zero & hi_one;
    end
  end

  // One-hot pivot match to binary run length.
  always_comb begin
    res          = '0;
    res.is_unary = |(m_true | m_cpl);
    res.is_cpl   = |m_cpl;
    for (int k = 0; k < W; k++) begin
      if (m_true[k] | m_cpl[k]) res.k = res.k | K_W'(k);
    end
  end

endmodule

// File: rtl/u_stream.sv
// ---------------------------------------------------------------------------
// u_stream -- two-stage valid/ready pipeline that classifies W-bit unary /
// complimented-unary (thermometer) codes and decodes their run length,
// carrying a sideband tag with each word.
//
// S0 registers the accepted word, u_classify sits between S0 and S1, and S1
// holds the result presented on the outputs. A stage loads whenever its
// successor is empty or draining, so up to two words are in flight and the
// pipe sustains one word per cycle while i_ready is high.
//
// Optional feature (macro U_STREAM_STATS_EN): saturating counters of
// admitted / rejected results consumed downstream, cleared by i_stat_clr
// (clear wins over a simultaneous consume). Without the macro the counter
// outputs are tied to 0 and i_stat_clr is ignored. CNT_W must not exceed 32.
//
// Ports:
//   i_clk, i_arst_n   clock, asynchronous active-low reset
//   i_valid/o_ready   input handshake; i_x word, i_tag sideband tag
//   o_valid/i_ready   output handshake
//   o_is_unary        admitted code      o_is_cpl  complimented form
//   o_k               decoded run length o_tag     tag of the result word
//   i_stat_clr        synchronous clear of the statistics counters
//   o_stat_adm/rej    admitted / rejected result counts
// ---------------------------------------------------------------------------
module u_stream
  import u_pkg::*;
#(
  parameter int unsigned W                     = U_W,
  parameter int unsigned P_ADMIT_COMPLIMENT_EN = 1,
  parameter int unsigned TAG_W                 = 4,
  parameter int unsigned CNT_W                 = 16
) (
  input  logic                 i_clk,
  input  logic                 i_arst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [W-1:0]         i_x,
  input  logic [TAG_W-1:0]     i_tag,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_is_unary,
  output logic                 o_is_cpl,
  output logic [$clog2(W)-1:0] o_k,
  output logic [TAG_W-1:0]     o_tag,
  input  logic                 i_stat_clr,
  output logic [CNT_W-1:0]     o_stat_adm,
  output logic [CNT_W-1:0]     o_stat_rej
);

  localparam int unsigned KO_W = $clog2(W);

  logic             s0_valid;
  logic [W-1:0]     s0_x;
  logic [TAG_W-1:0] s0_tag;
  logic             s1_valid;
  u_res_t           s1_res;
  logic [TAG_W-1:0] s1_tag;
  u_res_t           cls_res;
  logic             s1_load;

  // S1 can take a new entry when empty or being consumed this cycle; S0 can
  // when it is empty or moving into S1. o_ready never looks at i_valid.
  assign s1_load = !s1_valid || i_ready;
  assign o_ready = !s0_valid || s1_load;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and the two stages shift cleanly.
  // NOTE: the payload registers are reset as well, so the result outputs read
  // 0 out of reset rather than whatever the flops powered up with.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      s0_valid <= 1'b0;
      s0_x     <= '0;
      s0_tag   <= '0;
    end else if (o_ready) begin
      s0_valid <= i_valid;
      if (i_valid) begin
        s0_x   <= i_x;
        s0_tag <= i_tag;
      end
    end
  end

  u_classify #(
    .W                     (W),
    .P_ADMIT_COMPLIMENT_EN (P_ADMIT_COMPLIMENT_EN)
  ) u_cls (
    .x   (s0_x),
    .res (cls_res)
  );

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      s1_valid <= 1'b0;
      s1_res   <= '0;
      s1_tag   <= '0;
    end else if (s1_load) begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_res <= cls_res;
        s1_tag <= s0_tag;
      end
    end
  end

  assign o_valid    = s1_valid;
  assign o_is_unary = s1_res.is_unary;
  assign o_is_cpl   = s1_res.is_cpl;
  assign o_k        = KO_W'(s1_res.k);
  assign o_tag      = s1_tag;

`ifdef U_STREAM_STATS_EN
  localparam logic [STAT_MAX_W-1:0] CNT_MAX = STAT_MAX_W'({CNT_W{1'b1}});

  logic [CNT_W-1:0] stat_adm;
  logic [CNT_W-1:0] stat_rej;
  logic             consume;

  assign consume = s1_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      stat_adm <= '0;
      stat_rej <= '0;
    end else if (i_stat_clr) begin
      stat_adm <= '0;
      stat_rej <= '0;
    end else if (consume) begin
      if (s1_res.is_unary) stat_adm <= CNT_W'(sat_inc(STAT_MAX_W'(stat_adm), CNT_MAX));
      else                 stat_rej <= CNT_W'(sat_inc(STAT_MAX_W'(stat_rej), CNT_MAX));
    end
  end

  assign o_stat_adm = stat_adm;
  assign o_stat_rej = stat_rej;
`else
  logic stat_clr_unused;
  assign stat_clr_unused = i_stat_clr;
  assign o_stat_adm      = '0;
  assign o_stat_rej      = '0;
`endif

endmodule

// File: doc/u_stream.md
Name: u_stream

Overview:
- Pipelined, flow-controlled successor to the combinational unary/thermometer admission check.
- Accepts a stream of W-bit words using a valid/ready handshake.
- For each word it classifies the code (unary, complimented unary, or reject) and decodes the run length k.
- Carries a sideband tag alongside each word and returns the result two cycles after acceptance.
- Sits between a producer of thermometer-coded fields (e.g. FIFO occupancy or ADC flash outputs) and downstream binary consumers.

Parameters:
- W, 16: input width; legal range W >= 3.
- P_ADMIT_COMPLIMENT_EN, 1: when 1, complimented codes are also admitted.
- TAG_W, 4: width of the sideband tag carried with each word.
- CNT_W, 16: width of the statistics counters (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_arst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input word valid
- o_ready  out  1  block can accept an input word
- i_x  in  W  input code
- i_tag  in  TAG_W  sideband tag, passed through unchanged
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts the result
- o_is_unary  out  1  word is an admitted code
- o_is_cpl  out  1  admitted word was the complimented form
- o_k  out  $clog2(W)  decoded run length
- o_tag  out  TAG_W  tag of the result word
- i_stat_clr  in  1  synchronous clear of the statistics counters (optional feature only)
- o_stat_adm  out  CNT_W  count of admitted words (optional feature only)
- o_stat_rej  out  CNT_W  count of rejected words (optional feature only)

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_arst_n is asynchronous and active-low. All state clears on assertion; release is synchronous to i_clk.
- Reset values:
  - o_valid = 0, o_ready = 1.
  - o_is_unary = o_is_cpl = 0, o_k = 0, o_tag = 0.
  - Both statistics counters = 0.
- Admission rule:
  - Uncomplimented: i_x == (1<<k) - 1 for k in 0..W-1. All-zero is admitted with k = 0.
  - Complimented (only when P_ADMIT_COMPLIMENT_EN = 1): i_x == ~((1<<k) - 1) for k in 0..W-1. All-ones is admitted with k = 0 and o_is_cpl = 1.
  - All-ones is rejected when P_ADMIT_COMPLIMENT_EN = 0.
  - The two forms are disjoint for W >= 3, so no priority between them is needed.
- Rejected words: o_is_unary = 0, o_is_cpl = 0, o_k = 0. The tag is still returned.
- Pipeline:
  - S0 is the input register, written when i_valid & o_ready.
  - S1 is the result register, written from the S0 classification.
  - Latency: 2 cycles from the accept edge to o_valid.
  - Throughput: 1 word per cycle while i_ready = 1.
- Handshake:
  - Each stage advances when its successor is empty or draining.
  - o_ready = !s0_valid | !s1_valid | i_ready. This path is combinational from i_ready and must not depend on i_valid.
  - Results are consumed on o_valid & i_ready.
  - While o_valid = 1 and i_ready = 0, o_valid and all result outputs hold stable.
  - No word is dropped or duplicated. Order is preserved.
- Full condition: S0 and S1 both occupied with i_ready = 0 gives o_ready = 0. At most 2 words are in flight.
- Simultaneous accept and consume with the pipe full: both occur in the same cycle and occupancy is unchanged.
- Reset mid-operation: in-flight words are discarded and no partial result is presented.

Optional Feature:
- Macro: U_STREAM_STATS_EN.
- Defined:
  - o_stat_adm increments on each consumed result with o_is_unary = 1.
  - o_stat_rej increments on each consumed result with o_is_unary = 0.
  - Both counters saturate at 2^CNT_W - 1 and do not wrap.
  - i_stat_clr zeroes both counters. When a clear and a consume fall in the same cycle, the clear wins.
- Undefined:
  - The counter registers are absent.
  - o_stat_adm and o_stat_rej are tied to 0; i_stat_clr is ignored.

Decomposition:
- Package u_pkg holds:
  - the result struct {is_unary, is_cpl, k};
  - the localparam for the k width, $clog2(W);
  - the saturating-increment function.
- Sub-module u_classify: a combinational pivot-match classifier, W-bit word to result struct.
  - For each pivot: low-side all-match AND high-side all-match, in the true form and the complimented form.
  - k comes from the encoded pivot index.
- u_stream instantiates one u_classify between S0 and S1.

Test Plan:
- W=16, P=1, i_ready=1. Send 0x0000, 0x0007, 0x7FFF, 0xFFF8, 0xFFFF, 0x00F0 with tags 0..5. Expected results, each 2 cycles after its accept:
  - 0x0000 -> (1, 0, 0)
  - 0x0007 -> (1, 0, 3)
  - 0x7FFF -> (1, 0, 15)
  - 0xFFF8 -> (1, 1, 3)
  - 0xFFFF -> (1, 1, 0)
  - 0x00F0 -> (0, 0, 0)
  - Tags return in order 0..5.
- W=16, P=0:
  - 0xFFFF and 0xFFF8 -> o_is_unary = 0.
  - 0x0001 -> (1, 0, 1).
- Backpressure: stream 8 words back-to-back and hold i_ready = 0 for 5 cycles. Expected:
  - o_ready falls once 2 words are held.
  - Outputs stay stable while stalled.
  - All 8 results arrive in order after release.
- Accept and consume in the same cycle with the pipe full: throughput stays at 1/cycle with no loss.
- Assert i_arst_n low with 2 words in flight:
  - o_valid = 0 immediately, asynchronously.
  - After release, o_ready = 1 and no stale results appear.
- With U_STREAM_STATS_EN and CNT_W=4:
  - 20 admitted words -> o_stat_adm = 15, saturated.
  - 3 rejected words -> o_stat_rej = 3.
  - i_stat_clr asserted in the same cycle as a consume -> both counters = 0.
